// File: rtl/beeper_arbiter.sv
// Beeper tone-path arbiter: live keyboard play pre-empts the song autoplayer,
// with a release tail, silence gaps and articulation gaps between autoplay notes.
module beeper_arbiter #(
    parameter int unsigned HOLD_CYC  = 12000,
    parameter int unsigned GAP_CYC   = 60000,
    parameter int unsigned ARTIC_CYC = 6000,
    parameter int unsigned CNT_W     = 17
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] manual_key,
    input  logic [15:0] auto_tone,
    input  logic [2:0]  mode,
    output logic [15:0] tone_out,
    output logic        src_manual,
    output logic        auto_pause,
    output logic        muted
);

    localparam int unsigned HOLD_EFF  = (HOLD_CYC  == 0) ? 1 : HOLD_CYC;
    localparam int unsigned GAP_EFF   = (GAP_CYC   == 0) ? 1 : GAP_CYC;
    localparam int unsigned ARTIC_EFF = (ARTIC_CYC == 0) ? 1 : ARTIC_CYC;

    localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(HOLD_EFF - 1);
    localparam logic [CNT_W-1:0] GAP_LD   = CNT_W'(GAP_EFF - 1);
    localparam logic [CNT_W-1:0] ARTIC_LD = CNT_W'(ARTIC_EFF - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_AUTO,
        S_MANUAL,
        S_HOLD,
        S_GAP,
        S_ARTIC
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [15:0]      latched;
    logic [15:0]      prev_auto;
    logic [2:0]       prev_mode;
    logic             lock;

    logic [15:0] key_sel;
    logic        press;
    logic        auto_on;
    logic        mode_chg;
    logic        cnt_zero;
    logic        take_manual;
    logic        tone_step;

    always_comb begin
        // Two's-complement trick isolates the lowest set bit.
        key_sel     = manual_key & (~manual_key + 16'd1);
        press       = |manual_key;
        auto_on     = |mode;
        mode_chg    = (mode != prev_mode);
        cnt_zero    = (cnt == '0);
        // A key still held across a mode change stays locked out until the gap
        // expires or the key is released and pressed again.
        take_manual = press && ((state != S_GAP) || !lock || cnt_zero);
        tone_step   = (prev_auto != '0) && (auto_tone != '0) && (auto_tone != prev_auto);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            cnt        <= '0;
            latched    <= '0;
            prev_auto  <= '0;
            prev_mode  <= '0;
            lock       <= 1'b0;
            tone_out   <= '0;
            src_manual <= 1'b0;
            auto_pause <= 1'b0;
            muted      <= 1'b0;
        end else begin
            prev_mode  <= mode;
            prev_auto  <= auto_tone;
            tone_out   <= '0;
            src_manual <= 1'b0;
            auto_pause <= 1'b0;
            muted      <= 1'b0;

            if (mode_chg) begin
                state      <= S_GAP;
                cnt        <= GAP_LD;
                latched    <= '0;
                lock       <= press;
                muted      <= 1'b1;
                auto_pause <= auto_on;
            end else if (take_manual) begin
                state      <= S_MANUAL;
                latched    <= key_sel;
                lock       <= 1'b0;
                tone_out   <= key_sel;
                src_manual <= 1'b1;
                auto_pause <= auto_on;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (auto_on && (auto_tone != '0)) begin
                            state    <= S_AUTO;
                            tone_out <= auto_tone;
                        end
                    end

                    S_AUTO: begin
                        if (!auto_on) begin
                            state <= S_IDLE;
                        end else if (tone_step) begin
                            state <= S_ARTIC;
                            cnt   <= ARTIC_LD;
                            muted <= 1'b1;
                        end else begin
                            tone_out <= auto_tone;
                        end
                    end

                    S_MANUAL: begin
                        state      <= S_HOLD;
                        cnt        <= HOLD_LD;
                        tone_out   <= latched;
                        src_manual <= 1'b1;
                        auto_pause <= auto_on;
                    end

                    S_HOLD: begin
                        auto_pause <= auto_on;
                        if (cnt_zero) begin
                            state <= S_GAP;
                            cnt   <= GAP_LD;
                            lock  <= 1'b0;
                            muted <= 1'b1;
                        end else begin
                            cnt        <= cnt - CNT_W'(1);
                            tone_out   <= latched;
                            src_manual <= 1'b1;
                        end
                    end

                    S_GAP: begin
                        if (cnt_zero) begin
                            state <= S_IDLE;
                            lock  <= 1'b0;
                        end else begin
                            cnt        <= cnt - CNT_W'(1);
                            muted      <= 1'b1;
                            auto_pause <= auto_on;
                            if (!press) begin
                                lock <= 1'b0;
                            end
                        end
                    end

                    S_ARTIC: begin
                        if (cnt_zero) begin
                            state    <= S_AUTO;
                            tone_out <= auto_tone;
                        end else begin
                            cnt   <= cnt - CNT_W'(1);
                            muted <= 1'b1;
                        end
                    end

                    default: begin
                        state <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_beeper_arbiter.sv
// Self-checking bench for beeper_arbiter: per-cycle stimulus rows push the
// expected registered outputs to a scoreboard queue, popped after each clock edge.
module tb_beeper_arbiter;

    logic        clk;
    logic        rst_n;
    logic [15:0] manual_key;
    logic [15:0] auto_tone;
    logic [2:0]  mode;
    logic [15:0] tone_out;
    logic        src_manual;
    logic        auto_pause;
    logic        muted;

    int checks = 0;
    int errors = 0;

    // Expected outputs packed as {tone_out, src_manual, auto_pause, muted}.
    logic [18:0] sbq[$];

    typedef struct packed {
        logic [15:0] key;
        logic [15:0] at;
        logic [2:0]  md;
        logic [18:0] exp;
    } step_t;

    beeper_arbiter #(
        .HOLD_CYC (4),
        .GAP_CYC  (8),
        .ARTIC_CYC(2),
        .CNT_W    (17)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .manual_key(manual_key),
        .auto_tone (auto_tone),
        .mode      (mode),
        .tone_out  (tone_out),
        .src_manual(src_manual),
        .auto_pause(auto_pause),
        .muted     (muted)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [18:0] E(input logic [15:0] t, input logic s, input logic p,
                                      input logic m);
        return {t, s, p, m};
    endfunction

    function automatic step_t S(input logic [15:0] k, input logic [15:0] a, input logic [2:0] md,
                                input logic [18:0] e);
        step_t r;
        r.key = k;
        r.at  = a;
        r.md  = md;
        r.exp = e;
        return r;
    endfunction

    task automatic test_reset();
        step_t       st[$];
        logic [18:0] got;
        logic [18:0] want;
        rst_n      = 1'b0;
        manual_key = '0;
        auto_tone  = '0;
        mode       = 3'd0;
        #23;
        sbq.push_back(E(16'h0, 0, 0, 0));
        got  = {tone_out, src_manual, auto_pause, muted};
        want = sbq.pop_front();
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL reset_initial: got %h want %h", got, want);
        end
        @(negedge clk);
        rst_n = 1'b1;
        st.push_back(S(16'h0, 16'h0, 3'd0, E(16'h0, 0, 0, 0)));
        st.push_back(S(16'h0, 16'h0, 3'd2, E(16'h0, 0, 1, 1)));
        repeat (4) st.push_back(S(16'h0, 16'h0, 3'd2, E(16'h0, 0, 1, 1)));
        for (int i = 0; i < st.size(); i++) begin
            manual_key = st[i].key;
            auto_tone  = st[i].at;
            mode       = st[i].md;
            sbq.push_back(st[i].exp);
            @(posedge clk);
            #1;
            got  = {tone_out, src_manual, auto_pause, muted};
            want = sbq.pop_front();
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL reset_gap[%0d]: got %h want %h", i, got, want);
            end
        end
        // GAP counter now at 3: assert reset asynchronously, away from any edge.
        #2;
        rst_n = 1'b0;
        sbq.push_back(E(16'h0, 0, 0, 0));
        #1;
        got  = {tone_out, src_manual, auto_pause, muted};
        want = sbq.pop_front();
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL reset_async: got %h want %h", got, want);
        end
        mode = 3'd0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        st.delete();
        st.push_back(S(16'h0, 16'h0, 3'd0, E(16'h0, 0, 0, 0)));
        st.push_back(S(16'h0, 16'h0004, 3'd0, E(16'h0, 0, 0, 0)));
        for (int i = 0; i < st.size(); i++) begin
            manual_key = st[i].key;
            auto_tone  = st[i].at;
            mode       = st[i].md;
            sbq.push_back(st[i].exp);
            @(posedge clk);
            #1;
            got  = {tone_out, src_manual, auto_pause, muted};
            want = sbq.pop_front();
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL reset_idle[%0d]: got %h want %h", i, got, want);
            end
        end
    endtask

    task automatic test_auto();
        step_t       st[$];
        logic [18:0] got;
        logic [18:0] want;
        st.push_back(S(16'h0, 16'h0, 3'd1, E(16'h0, 0, 1, 1)));
        repeat (7) st.push_back(S(16'h0, 16'h0, 3'd1, E(16'h0, 0, 1, 1)));
        st.push_back(S(16'h0, 16'h0, 3'd1, E(16'h0, 0, 0, 0)));
        st.push_back(S(16'h0, 16'h0004, 3'd1, E(16'h0004, 0, 0, 0)));
        st.push_back(S(16'h0, 16'h0004, 3'd1, E(16'h0004, 0, 0, 0)));
        for (int i = 0; i < st.size(); i++) begin
            manual_key = st[i].key;
            auto_tone  = st[i].at;
            mode       = st[i].md;
            sbq.push_back(st[i].exp);
            @(posedge clk);
            #1;
            got  = {tone_out, src_manual, auto_pause, muted};
            want = sbq.pop_front();
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL auto[%0d]: got %h want %h", i, got, want);
            end
        end
    endtask

    task automatic test_preempt();
        step_t       st[$];
        logic [18:0] got;
        logic [18:0] want;
        repeat (2) st.push_back(S(16'h0030, 16'h0004, 3'd1, E(16'h0010, 1, 1, 0)));
        repeat (4) st.push_back(S(16'h0, 16'h0004, 3'd1, E(16'h0010, 1, 1, 0)));
        repeat (8) st.push_back(S(16'h0, 16'h0004, 3'd1, E(16'h0, 0, 1, 1)));
        st.push_back(S(16'h0, 16'h0004, 3'd1, E(16'h0, 0, 0, 0)));
        st.push_back(S(16'h0, 16'h0004, 3'd1, E(16'h0004, 0, 0, 0)));
        for (int i = 0; i < st.size(); i++) begin
            manual_key = st[i].key;
            auto_tone  = st[i].at;
            mode       = st[i].md;
            sbq.push_back(st[i].exp);
            @(posedge clk);
            #1;
            got  = {tone_out, src_manual, auto_pause, muted};
            want = sbq.pop_front();
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL preempt[%0d]: got %h want %h", i, got, want);
            end
        end
    endtask

    task automatic test_artic();
        step_t       st[$];
        logic [18:0] got;
        logic [18:0] want;
        st.push_back(S(16'h0, 16'h0000, 3'd1, E(16'h0000, 0, 0, 0)));
        st.push_back(S(16'h0, 16'h0002, 3'd1, E(16'h0002, 0, 0, 0)));
        st.push_back(S(16'h0, 16'h0002, 3'd1, E(16'h0002, 0, 0, 0)));
        st.push_back(S(16'h0, 16'h0008, 3'd1, E(16'h0000, 0, 0, 1)));
        st.push_back(S(16'h0, 16'h0008, 3'd1, E(16'h0000, 0, 0, 1)));
        st.push_back(S(16'h0, 16'h0008, 3'd1, E(16'h0008, 0, 0, 0)));
        st.push_back(S(16'h0, 16'h0008, 3'd1, E(16'h0008, 0, 0, 0)));
        st.push_back(S(16'h0, 16'h0000, 3'd1, E(16'h0000, 0, 0, 0)));
        st.push_back(S(16'h0, 16'h0002, 3'd1, E(16'h0002, 0, 0, 0)));
        st.push_back(S(16'h0, 16'h0000, 3'd1, E(16'h0000, 0, 0, 0)));
        st.push_back(S(16'h0, 16'h0008, 3'd1, E(16'h0008, 0, 0, 0)));
        for (int i = 0; i < st.size(); i++) begin
            manual_key = st[i].key;
            auto_tone  = st[i].at;
            mode       = st[i].md;
            sbq.push_back(st[i].exp);
            @(posedge clk);
            #1;
            got  = {tone_out, src_manual, auto_pause, muted};
            want = sbq.pop_front();
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL artic[%0d]: got %h want %h", i, got, want);
            end
        end
    endtask

    task automatic test_repress();
        step_t       st[$];
        logic [18:0] got;
        logic [18:0] want;
        st.push_back(S(16'h0020, 16'h0008, 3'd1, E(16'h0020, 1, 1, 0)));
        st.push_back(S(16'h0000, 16'h0008, 3'd1, E(16'h0020, 1, 1, 0)));
        st.push_back(S(16'h0000, 16'h0008, 3'd1, E(16'h0020, 1, 1, 0)));
        st.push_back(S(16'h0080, 16'h0008, 3'd1, E(16'h0080, 1, 1, 0)));
        st.push_back(S(16'h0080, 16'h0008, 3'd1, E(16'h0080, 1, 1, 0)));
        for (int i = 0; i < st.size(); i++) begin
            manual_key = st[i].key;
            auto_tone  = st[i].at;
            mode       = st[i].md;
            sbq.push_back(st[i].exp);
            @(posedge clk);
            #1;
            got  = {tone_out, src_manual, auto_pause, muted};
            want = sbq.pop_front();
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL repress[%0d]: got %h want %h", i, got, want);
            end
        end
    endtask

    task automatic test_mode_change();
        step_t       st[$];
        logic [18:0] got;
        logic [18:0] want;
        repeat (8) st.push_back(S(16'h0080, 16'h0008, 3'd0, E(16'h0, 0, 0, 1)));
        st.push_back(S(16'h0080, 16'h0008, 3'd0, E(16'h0080, 1, 0, 0)));
        repeat (8) st.push_back(S(16'h0080, 16'h0008, 3'd2, E(16'h0, 0, 1, 1)));
        st.push_back(S(16'h0080, 16'h0008, 3'd2, E(16'h0080, 1, 1, 0)));
        repeat (8) st.push_back(S(16'h0, 16'hFFFF, 3'd0, E(16'h0, 0, 0, 1)));
        repeat (3) st.push_back(S(16'h0, 16'hFFFF, 3'd0, E(16'h0, 0, 0, 0)));
        st.push_back(S(16'hFF00, 16'hFFFF, 3'd0, E(16'h0100, 1, 0, 0)));
        for (int i = 0; i < st.size(); i++) begin
            manual_key = st[i].key;
            auto_tone  = st[i].at;
            mode       = st[i].md;
            sbq.push_back(st[i].exp);
            @(posedge clk);
            #1;
            got  = {tone_out, src_manual, auto_pause, muted};
            want = sbq.pop_front();
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL mode_change[%0d]: got %h want %h", i, got, want);
            end
        end
    endtask

    initial begin
        test_reset();
        test_auto();
        test_preempt();
        test_artic();
        test_repress();
        test_mode_change();
        checks++;
        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d entries want 0", sbq.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
